// File: rtl/stream_arb_pkg.sv
// stream_arb_pkg: shared ID-width helper and beat type for the stream round-robin arbiter.
package stream_arb_pkg;
  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_DATA_WIDTH = 8;
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  localparam int DEF_ID_WIDTH = id_width(DEF_NUM_REQ);
  typedef struct packed {
    logic [DEF_DATA_WIDTH-1:0] data;
    logic [DEF_ID_WIDTH-1:0]   id;
    logic                      last;
  } beat_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin pick via double-width rotate and priority encode.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);
  localparam logic [IW:0] N_V = (IW+1)'(N);
  logic [2*N-1:0] dbl;
  logic [IW-1:0]  off;
  logic [IW:0]    sum;
  always_comb begin
    dbl = {req, req} >> ptr;
    any = |dbl[N-1:0];
    off = '0;
    for (int i = N - 1; i >= 0; i--) off = dbl[i] ? IW'(i) : off;
    sum = {1'b0, ptr} + {1'b0, off};
    idx = IW'((sum >= N_V) ? sum - N_V : sum);
    gnt = any ? (N'(1) << idx) : '0;
  end
endmodule

// File: rtl/stream_rr_arbiter.sv
// stream_rr_arbiter: round-robin N:1 valid/ready arbiter feeding a registered output stage.
// Define STREAM_ARB_LOCK_EN to add req_last/out_last and hold the grant for a whole packet.
module stream_rr_arbiter
  import stream_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ID_WIDTH   = id_width(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [ID_WIDTH-1:0]           out_id
`ifdef STREAM_ARB_LOCK_EN
  ,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic                          out_last
`endif
);
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [ID_WIDTH-1:0]   out_id_q, out_id_d;
  logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]    cand, gnt;
  logic [ID_WIDTH-1:0]   idx, idx_inc;
  logic                  any, can_load, xfer, pkt_end;

`ifdef STREAM_ARB_LOCK_EN
  logic                lock_q, lock_d;
  logic [ID_WIDTH-1:0] lock_id_q, lock_id_d;
  logic                out_last_q, out_last_d;
  // While locked only the packet owner is a candidate; others wait.
  assign cand    = lock_q ? (req_valid & (NUM_REQ'(1) << lock_id_q)) : req_valid;
  assign pkt_end = req_last[idx];
  assign out_last = out_last_q;
  always_comb begin
    lock_d     = xfer ? !pkt_end : lock_q;
    lock_id_d  = xfer ? idx : lock_id_q;
    out_last_d = xfer ? pkt_end : out_last_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      lock_q     <= 1'b0;
      lock_id_q  <= '0;
      out_last_q <= 1'b0;
    end else begin
      lock_q     <= lock_d;
      lock_id_q  <= lock_id_d;
      out_last_q <= out_last_d;
    end
`else
  assign cand    = req_valid;
  assign pkt_end = 1'b1;
`endif

  rr_pick #(.N(NUM_REQ), .IW(ID_WIDTH)) u_pick (
    .req(cand),
    .ptr(rr_ptr_q),
    .gnt(gnt),
    .idx(idx),
    .any(any)
  );

  assign can_load  = !out_valid_q || out_ready;
  assign xfer      = any && can_load && !rst;
  assign req_ready = xfer ? gnt : '0;
  assign idx_inc   = (idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : idx + ID_WIDTH'(1);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;

  always_comb begin
    out_valid_d = xfer || (out_valid_q && !out_ready);
    out_data_d  = xfer ? req_data[idx*DATA_WIDTH +: DATA_WIDTH] : out_data_q;
    out_id_d    = xfer ? idx : out_id_q;
    rr_ptr_d    = (xfer && pkt_end) ? idx_inc : rr_ptr_q;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      rr_ptr_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      rr_ptr_q    <= rr_ptr_d;
    end
endmodule

// File: doc/stream_rr_arbiter.md
Name: stream_rr_arbiter

Overview:
- Shares one registered valid/ready output stage between NUM_REQ valid/ready requesters, using round-robin arbitration.
- Sits upstream of a pipeline register chain; it sequences which producer owns the downstream datapath each cycle.
- Winner's data and source index are captured into an output register.
- Full throughput when downstream is always ready; stall-stable output under backpressure.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
DATA_WIDTH, 8, payload width per requester
ID_WIDTH, $clog2(NUM_REQ), width of out_id (derived; do not override)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  per-requester valid
req_ready  out  NUM_REQ  per-requester ready; at most one bit set
req_data  in  NUM_REQ*DATA_WIDTH  payload; requester i at bits [i*DATA_WIDTH +: DATA_WIDTH]
out_valid  out  1  output register holds a beat
out_ready  in  1  downstream ready
out_data  out  DATA_WIDTH  registered payload
out_id  out  ID_WIDTH  index of requester that supplied out_data
req_last  in  NUM_REQ  last beat of packet (only with STREAM_ARB_LOCK_EN)
out_last  out  1  registered last flag (only with STREAM_ARB_LOCK_EN)

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_id=0, out_last=0, rr_ptr=0 (requester 0 highest priority); req_ready=0 while rst high.
- Slot accept: can_load = !out_valid || out_ready (combinational, same as a full-throughput pipeline register).
- Grant: when can_load, grant = first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ. req_ready[grant]=1; all other bits 0. No valid request, or !can_load: req_ready=0.
- Transfer at edge when req_valid[g] && req_ready[g]: out_data<=req_data[g], out_id<=g, out_valid<=1, rr_ptr<=(g+1) mod NUM_REQ. Wrap: g=NUM_REQ-1 gives rr_ptr=0.
- Output handshake with no new grant: out_valid && out_ready -> out_valid<=0.
- Simultaneous downstream pop and upstream grant in the same cycle: register reloads; out_valid stays 1; no bubble.
- Latency: 1 cycle from input handshake to out_valid.
- Throughput: 1 beat/cycle with out_ready held high.
- Stall: out_valid && !out_ready -> out_data, out_id, out_last are held bit-stable; req_ready all 0.
- rr_ptr changes only on an upstream transfer.
- Fairness: with all requesters continuously valid, grants cycle 0,1,...,NUM_REQ-1,0. Any valid requester is granted within NUM_REQ transfers.
- Requester dropping req_valid before it is granted is legal; it is skipped without penalty.
- Reset mid-transfer: the held beat is discarded; out_valid drops immediately (async).

Optional Feature:
STREAM_ARB_LOCK_EN
- Defined: adds req_last and out_last. After granting requester g with req_last[g]=0, the arbiter locks to g. In later accept cycles only g may be granted, even if g is not valid (others wait). Lock releases on transfer of a beat with req_last[g]=1. rr_ptr advances only at packet end. out_last is registered with the data. Reset clears the lock.
- Undefined: ports absent; every beat is arbitrated independently.

Decomposition:
- Package stream_arb_pkg: function clog2-safe ID width helper, and a typedef for a packed beat struct {data, id, last} parameterised via localparam defaults.
- One sub-module rr_pick: combinational. Inputs req vector and rr_ptr; outputs a one-hot grant, an encoded index and any_req. Implemented as a double-width rotate-and-priority-encode.
- Arbiter top holds the output register, rr_ptr and lock state.

Test Plan:
- Reset with req_valid=4'b1111: out_valid=0, req_ready=0 during rst. First grant after release is id 0.
- All four valid, data i=8'h10+i, out_ready=1: out_id sequence 0,1,2,3,0 on consecutive cycles; out_data 10,11,12,13,10; no bubbles.
- Only req 2 valid with out_ready=0 for 5 cycles: one beat 8'h12 captured; out_data and out_id=2 stable for all 5 stall cycles; req_ready=0 throughout.
- rr_ptr=3 with req_valid=4'b1001: grant 3, then 0 (wrap-around); then with 4'b1001 again, grant 3.
- Assert rst while out_valid=1 holding 8'hAA: out_valid=0 immediately; after release, first grant restarts at id 0.
- STREAM_ARB_LOCK_EN: req 1 sends 3 beats (last on 3rd) while req 0 is valid. Outputs are ids 1,1,1 then 0; out_last=1 only on the third beat.
